// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, computing
// a+b+cin LSB-first over WIDTH clocks between two valid/ready handshakes.

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);
endmodule

// state | meaning
// IDLE  | in_ready=1, waiting for in_valid; accepting edge loads operands
// RUN   | one sum bit per edge, LSB first, for WIDTH edges
// DONE  | out_valid=1, result held until out_ready
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;

    full_adder_cell u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .c  (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (cnt == CNT_LAST) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake flags depend on the registered state only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        carry  <= cin;
                        cnt    <= '0;
                        sum_sr <= '0;
                    end
                end
                RUN: begin
                    // After WIDTH shifts the first sum bit lands in bit 0.
                    sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    carry  <= fa_co;
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_sr;
    assign cout = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH 8, 2 and 32: constant vector table, directed
// corner sequences and randomized traffic against an arithmetic reference.

module tb_serial_adder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv   [3];
    logic        ordy [3];
    logic        cinv [3];
    logic [63:0] av   [3];
    logic [63:0] bv   [3];
    logic        ir   [3];
    logic        ov   [3];
    logic        co   [3];
    logic [63:0] sm   [3];

    logic [7:0]  sum8;
    logic [1:0]  sum2;
    logic [31:0] sum32;
    logic        ir8, ir2, ir32, ov8, ov2, ov32, co8, co2, co32;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir8),
        .a(av[0][7:0]), .b(bv[0][7:0]), .cin(cinv[0]),
        .out_valid(ov8), .out_ready(ordy[0]), .sum(sum8), .cout(co8));
    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir2),
        .a(av[1][1:0]), .b(bv[1][1:0]), .cin(cinv[1]),
        .out_valid(ov2), .out_ready(ordy[1]), .sum(sum2), .cout(co2));
    serial_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir32),
        .a(av[2][31:0]), .b(bv[2][31:0]), .cin(cinv[2]),
        .out_valid(ov32), .out_ready(ordy[2]), .sum(sum32), .cout(co32));

    assign ir[0] = ir8;  assign ir[1] = ir2;  assign ir[2] = ir32;
    assign ov[0] = ov8;  assign ov[1] = ov2;  assign ov[2] = ov32;
    assign co[0] = co8;  assign co[1] = co2;  assign co[2] = co32;
    assign sm[0] = 64'(sum8);
    assign sm[1] = 64'(sum2);
    assign sm[2] = 64'(sum32);

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    function automatic int wof(input int k);
        case (k)
            0:       return 8;
            1:       return 2;
            default: return 32;
        endcase
    endfunction

    function automatic logic [63:0] wmask(input int w);
        logic [64:0] one;
        one = 65'd1;
        return 64'((one << w) - 65'd1);
    endfunction

    function automatic logic [63:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return '1;
            1:       return '0;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full transaction on instance k, checked against plain a+b+cin.
    task automatic do_op(input int k, input logic [63:0] a_in, input logic [63:0] b_in,
                         input logic c_in, input int stall, input bit disturb,
                         input bit hold_iv, output logic [63:0] got_sum, output logic got_cout);
        int          w;
        int          n;
        logic [63:0] m;
        logic [64:0] full;
        logic [63:0] exp_sum;
        logic        exp_cout;
        w        = wof(k);
        m        = wmask(w);
        full     = {1'b0, a_in & m} + {1'b0, b_in & m} + 65'(c_in);
        exp_sum  = full[63:0] & m;
        exp_cout = full[w];

        n = 0;
        while (!ir[k] && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_before_accept", 64'(ir[k]), 64'd1);
        av[k] = a_in & m; bv[k] = b_in & m; cinv[k] = c_in; iv[k] = 1'b1;
        @(posedge clk); #1;
        iv[k] = 1'b0;
        chk("in_ready_after_accept", 64'(ir[k]), 64'd0);

        n = 0;
        while (!ov[k] && n < 200) begin
            if (disturb) begin
                av[k] = rnd_op() & m; bv[k] = rnd_op() & m;
                cinv[k] = 1'($urandom); iv[k] = 1'($urandom); ordy[k] = 1'($urandom);
            end
            @(posedge clk); #1; n++;
            if (disturb && !ov[k]) chk("in_ready_during_run", 64'(ir[k]), 64'd0);
        end
        iv[k] = 1'b0; ordy[k] = 1'b0;
        chk("latency", 64'(n), 64'(w));
        chk("sum", sm[k], exp_sum);
        chk("cout", 64'(co[k]), 64'(exp_cout));
        got_sum  = sm[k];
        got_cout = co[k];

        if (hold_iv) begin
            av[k] = ~a_in & m; bv[k] = ~b_in & m; iv[k] = 1'b1;
        end
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("stall_out_valid", 64'(ov[k]), 64'd1);
            chk("stall_in_ready", 64'(ir[k]), 64'd0);
            chk("stall_sum", sm[k], exp_sum);
            chk("stall_cout", 64'(co[k]), 64'(exp_cout));
        end
        ordy[k] = 1'b1;
        @(posedge clk); #1;
        ordy[k] = 1'b0;
        iv[k]   = 1'b0;
        chk("release_out_valid", 64'(ov[k]), 64'd0);
        chk("release_in_ready", 64'(ir[k]), 64'd1);
        chk("release_sum_held", sm[k], exp_sum);
        chk("release_cout_held", 64'(co[k]), 64'(exp_cout));
    endtask

    vec_t        vecs[6];
    logic [63:0] gs;
    logic        gc;

    initial begin
        for (int k = 0; k < 3; k++) begin
            iv[k] = 0; ordy[k] = 0; cinv[k] = 0; av[k] = '0; bv[k] = '0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", 64'(ir[0]), 64'd1);
        chk("reset_out_valid", 64'(ov[0]), 64'd0);
        chk("reset_sum", sm[0], 64'd0);
        chk("reset_cout", 64'(co[0]), 64'd0);
        rst = 1'b0;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
        for (int i = 0; i < 6; i++) begin
            do_op(0, 64'(vecs[i].a), 64'(vecs[i].b), vecs[i].cin, 0, 1'b0, 1'b0, gs, gc);
            chk("table_sum", gs, 64'(vecs[i].exp_sum));
            chk("table_cout", 64'(gc), 64'(vecs[i].exp_cout));
        end

        // Backpressure with new operands offered while the result is held.
        do_op(0, 64'h12, 64'h34, 1'b1, 5, 1'b0, 1'b1, gs, gc);
        chk("bp_sum", gs, 64'h47);
        // Operand churn and in_valid pulses while running.
        do_op(0, 64'hC3, 64'h5A, 1'b1, 1, 1'b1, 1'b0, gs, gc);
        chk("disturb_sum", gs, 64'h1E);
        chk("disturb_cout", 64'(gc), 64'd1);

        // Reset in the middle of RUN.
        av[0] = 64'h55; bv[0] = 64'h66; cinv[0] = 1'b1; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrun_rst_out_valid", 64'(ov[0]), 64'd0);
        chk("midrun_rst_in_ready", 64'(ir[0]), 64'd1);
        chk("midrun_rst_sum", sm[0], 64'd0);
        chk("midrun_rst_cout", 64'(co[0]), 64'd0);
        #1;
        rst = 1'b0;
        do_op(0, 64'h10, 64'h20, 1'b0, 0, 1'b0, 1'b0, gs, gc);
        chk("post_rst_sum", gs, 64'h30);
        chk("post_rst_cout", 64'(gc), 64'd0);

        for (int k = 0; k < 3; k++) begin
            int nops;
            nops = (k == 0) ? 1000 : 300;
            for (int i = 0; i < nops; i++) begin
                do_op(k, rnd_op(), rnd_op(), 1'($urandom), int'($urandom_range(0, 3)),
                      1'($urandom), 1'($urandom), gs, gc);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial N-bit adder built around the team's 1-bit full-adder cell (a+b+c -> {carry,sum}), plus a carry flip-flop and shift registers. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake. It computes the sum LSB-first, one bit per clock, and presents the WIDTH-bit sum and carry-out over a second valid/ready handshake. It is the sequential consumer of the full-adder cell and trades area for WIDTH-cycle latency.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 2..64.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands a, b, cin are valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in
out_valid  output  1  sum/cout valid (high only in DONE)
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result, (a+b+cin) mod 2^WIDTH
cout  output  1  carry-out, bit WIDTH of a+b+cin

Behaviour:
- Reset (async, on rst=1):
  - state=IDLE.
  - The a/b shift registers, sum register, carry FF and bit counter all clear to 0.
  - Outputs: in_ready=1, out_valid=0, sum=0, cout=0.
- States: IDLE, RUN, DONE. Registered state; in_ready and out_valid are decoded from state only (no combinational path from inputs).
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: load A_sr<=a, B_sr<=b, carry<=cin, cnt<=0; clear the sum register to 0; go to RUN.
  - With in_valid=0: stay in IDLE.
- RUN (in_ready=0, out_valid=0): each edge:
  - Apply the full-adder cell to A_sr[0], B_sr[0], carry.
  - Shift the sum register right, inserting the cell sum bit at MSB.
  - Shift A_sr and B_sr right, inserting 0.
  - carry <= cell carry.
  - If cnt==WIDTH-1, go to DONE; else cnt<=cnt+1.
- Counter width is $clog2(WIDTH); it never wraps past WIDTH-1.
- DONE:
  - out_valid=1; sum = sum register, cout = carry FF.
  - Both are held stable until the handshake completes.
  - On an edge with out_ready=1: go to IDLE; sum and cout keep their last values.
  - With out_ready=0: stay in DONE indefinitely (backpressure).
- Latency: out_valid rises exactly WIDTH clock edges after the accepting edge.
  - Minimum initiation interval is WIDTH+2 cycles (RUN×WIDTH, DONE≥1, IDLE≥1).
  - No accept occurs in DONE, even if in_valid and out_ready are both high.
- in_valid while in RUN or DONE is ignored; a/b/cin are sampled only on the accepting edge, so input changes after acceptance do not affect the result.
- out_ready outside DONE has no effect.
- Reset asserted mid-RUN or in DONE aborts the operation immediately: the result is discarded, out_valid drops to 0 asynchronously, and the state returns to IDLE.
- Arithmetic: {cout,sum} equals a+b+cin computed at WIDTH+1 bits, for all inputs including all-ones overflow.

Test Plan:
- WIDTH=8, a=8'h5A, b=8'h3C, cin=0, out_ready=1 -> out_valid high 8 edges after accept; sum=8'h96, cout=0; in_ready returns 1 one cycle after the out handshake.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1; a=0, b=0, cin=1 -> sum=8'h01, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> state stays DONE with sum/cout/out_valid unchanged; in_valid=1 with new operands is not accepted (in_ready=0); result is released on the out_ready=1 edge.
- Mid-RUN disturbance: change a/b and pulse in_valid during RUN -> result still matches the originally accepted operands; in_ready stays 0.
- Reset at cycle 3 of RUN -> out_valid=0, in_ready=1, sum=0, cout=0 immediately; the next operation (8'h10+8'h20, cin=0) yields 8'h30, cout=0.
- Randomized regression: 1000 random a/b/cin with random out_ready stalls -> every {cout,sum} equals a+b+cin; latency is always exactly WIDTH; also run with WIDTH=2 and WIDTH=32.
